// File: rtl/hex_display_ctrl_pkg.sv
// Shared constants for the HEX display controller: segment patterns,
// FSM state encoding and the largest value the digit slots can show.
package hex_display_ctrl_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_SCAN = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // 10^n_digits - 1, the largest value that fits in the display.
  function automatic logic [63:0] max_display(input int n_digits);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n_digits; i++) r = r * 64'd10;
    return r - 64'd1;
  endfunction

endpackage

// File: rtl/hex_display_ctrl_if.sv
// Load/status/segment bundle between the datapath and the display controller.
interface hex_display_ctrl_if #(
  parameter int N_BITS   = 20,
  parameter int N_DIGITS = 6
);
  logic [N_BITS-1:0]     valor;
  logic                  carregar;
  logic                  ocupado;
  logic                  pronto;
  logic [7*N_DIGITS-1:0] hex;

  modport master (output valor, carregar, input ocupado, pronto, hex);
  modport slave  (input valor, carregar, output ocupado, pronto, hex);
endinterface

// File: rtl/cb7s.sv
// Registered BCD/hex to active-low seven-segment decoder (bit0 = a .. bit6 = g).
module cb7s (
  input  logic       clk,
  input  logic [3:0] code,
  output logic [6:0] seg
);

  // NOTE: no reset here; the output is always rewritten before anyone consumes it.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    case (code)
      4'h0: seg <= 7'b1000000;
      4'h1: seg <= 7'b1111001;
      4'h2: seg <= 7'b0100100;
      4'h3: seg <= 7'b0110000;
      4'h4: seg <= 7'b0011001;
      4'h5: seg <= 7'b0010010;
      4'h6: seg <= 7'b0000010;
      4'h7: seg <= 7'b1111000;
      4'h8: seg <= 7'b0000000;
      4'h9: seg <= 7'b0010000;
      4'hA: seg <= 7'b0001000;
      4'hB: seg <= 7'b0000011;
      4'hC: seg <= 7'b1000110;
      4'hD: seg <= 7'b0100001;
      4'hE: seg <= 7'b0000110;
      default: seg <= 7'b0001110;
    endcase
  end

endmodule

// File: rtl/hex_display_ctrl_bin_bcd_seq.sv
// Iterative shift-add-3 binary to BCD converter, one input bit per clock.
module bin_bcd_seq #(
  parameter int N_BITS   = 20,
  parameter int N_DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [N_BITS-1:0]     bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*N_DIGITS-1:0] bcd
);

  localparam int CW = $clog2(N_BITS + 1);

  logic [N_BITS-1:0]     bin_q;
  logic [CW-1:0]         cnt;
  logic [4*N_DIGITS-1:0] bcd_adj;

  // NOTE: the default assignment first keeps this combinational block latch-free.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // High during the cycle whose closing edge performs the final shift.
  assign done = busy && (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      busy  <= 1'b0;
      cnt   <= '0;
      bin_q <= '0;
      bcd   <= '0;
    end else if (start && !busy) begin
      busy  <= 1'b1;
      cnt   <= CW'(N_BITS);
      bin_q <= bin_in;
      bcd   <= '0;
    end else if (busy) begin
      bcd   <= {bcd_adj[4*N_DIGITS-2:0], bin_q[N_BITS-1]};
      bin_q <= {bin_q[N_BITS-2:0], 1'b0};
      cnt   <= cnt - CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// Converts a binary value to BCD, scans the digits through one shared decoder
// into a shadow register, then updates all HEX displays in a single cycle.
module hex_display_ctrl
  import hex_display_ctrl_pkg::*;
#(
  parameter int N_BITS      = 20,
  parameter int N_DIGITS    = 6,
  parameter int BLANK_ZEROS = 1
) (
  input  logic           clk,
  input  logic           reset,
  hex_display_ctrl_if.slave bus
);

  localparam int SW = $clog2(N_DIGITS + 1);

  logic [1:0]            state;
  logic                  ovf;
  logic [SW-1:0]         scan_cnt;
  logic [7*N_DIGITS-1:0] shadow;
  logic [7*N_DIGITS-1:0] hex_q;
  logic [7*N_DIGITS-1:0] hex_next;
  logic                  pronto_q;
  logic                  seen_nz;

  logic                  conv_start;
  logic                  conv_busy;
  logic                  conv_done;
  logic [4*N_DIGITS-1:0] bcd;
  logic [3:0]            dec_code;
  logic [6:0]            dec_seg;

  assign conv_start = (state == ST_IDLE) && bus.carregar && !conv_busy;

  bin_bcd_seq #(.N_BITS(N_BITS), .N_DIGITS(N_DIGITS)) u_conv (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin_in(bus.valor),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  always_comb begin
    dec_code = 4'd0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (scan_cnt == SW'(i)) dec_code = bcd[4*i +: 4];
    end
  end

  cb7s u_dec (.clk(clk), .code(dec_code), .seg(dec_seg));

  // Overrides applied at copy time; walking top-down finds the leading zeros.
  always_comb begin
    hex_next = shadow;
    seen_nz  = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if (bcd[4*i +: 4] != 4'd0) seen_nz = 1'b1;
      if (ovf)
        hex_next[7*i +: 7] = SEG_DASH;
      else if ((BLANK_ZEROS != 0) && !seen_nz && (i != 0))
        hex_next[7*i +: 7] = SEG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ovf      <= 1'b0;
      scan_cnt <= '0;
      shadow   <= '0;
      hex_q    <= {N_DIGITS{SEG_BLANK}};
      pronto_q <= 1'b0;
    end else begin
      pronto_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (conv_start) begin
            ovf   <= 64'(bus.valor) > max_display(N_DIGITS);
            state <= ST_CONV;
          end
        end
        ST_CONV: begin
          if (conv_done) begin
            scan_cnt <= '0;
            state    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // Decoder output lags its input by one cycle, hence slot k-1.
          for (int i = 0; i < N_DIGITS; i++) begin
            if (scan_cnt == SW'(i + 1)) shadow[7*i +: 7] <= dec_seg;
          end
          if (scan_cnt == SW'(N_DIGITS)) state <= ST_DONE;
          else scan_cnt <= scan_cnt + SW'(1);
        end
        default: begin
          hex_q    <= hex_next;
          pronto_q <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ocupado = (state != ST_IDLE);
  assign bus.pronto  = pronto_q;
  assign bus.hex     = hex_q;

endmodule
